// File: rtl/div_arbiter_pkg.sv
// div_arbiter_pkg: state encoding and divider handshake constants shared by div_arbiter
// and any other arbiter that drives the same multi-cycle divider.
package div_arbiter_pkg;

  typedef enum logic [1:0] {
    DivArbIdle   = 2'd0,
    DivArbBusy   = 2'd1,
    DivArbStop   = 2'd2,
    DivArbCancel = 2'd3
  } div_arb_state_e;

  // Divider handshake levels.
  localparam logic DivStart       = 1'b1;
  localparam logic DivStop        = 1'b0;
  localparam logic DivResultReady = 1'b1;

  // Annul is held this many cycles so a divider parked in its end or
  // divide-by-zero state is also returned to free.
  localparam int unsigned CancelCycles = 2;

endpackage

// File: rtl/div_arbiter_rr_picker.sv
// div_arbiter_rr_picker: combinational round-robin picker. Searches the eligible vector
// starting one past i_last and returns a one-hot pick plus a valid flag.
module div_arbiter_rr_picker #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_eligible,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_pick,
  output logic          o_valid
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the loop leaves a value held and infers a latch.
  always_comb begin
    o_pick  = '0;
    o_valid = 1'b0;
    for (int off = 1; off <= N; off++) begin
      automatic int idx = int'(i_last) + off;
      if (idx >= N) idx = idx - N;
      if (!o_valid && i_eligible[IW'(idx)]) begin
        o_pick[IW'(idx)] = 1'b1;
        o_valid          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: shares one multi-cycle divider among NUM_REQ requesters (round-robin).
// Optional feature macro: DIV_ARB_ZERO_BYPASS_EN answers zero-divisor picks in IDLE directly.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ-1:0]      cancel_i,
  input  logic [NUM_REQ-1:0]      signed_i,
  input  logic [32*NUM_REQ-1:0]   opdata1_i,
  input  logic [32*NUM_REQ-1:0]   opdata2_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [NUM_REQ-1:0]      done_o,
  output logic [63:0]             result_o,
  output logic                    busy_o,
  output logic                    div_start_o,
  output logic                    div_annul_o,
  output logic                    div_signed_o,
  output logic [31:0]             div_opdata1_o,
  output logic [31:0]             div_opdata2_o,
  input  logic [63:0]             div_result_i,
  input  logic                    div_ready_i
);

  localparam int OW = $clog2(NUM_REQ);

  div_arb_state_e     r_state, w_next_state;
  logic [OW-1:0]      r_owner, r_last, w_pick_idx;
  logic               r_signed;
  logic [31:0]        r_op1, r_op2;
  logic [63:0]        r_result;
  logic [NUM_REQ-1:0] r_done;
  logic [1:0]         r_cnt;

  logic [NUM_REQ-1:0] w_eligible, w_pick, w_gnt;
  logic               w_pick_valid;
  logic [31:0]        w_op1 [NUM_REQ];
  logic [31:0]        w_op2 [NUM_REQ];
  logic               w_grant, w_finish, w_cancel, w_bypass;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign w_op1[k] = opdata1_i[32*k +: 32];
    assign w_op2[k] = opdata2_i[32*k +: 32];
  end

  // A requester flushing itself is never picked.
  assign w_eligible = req_i & ~cancel_i;

  div_arbiter_rr_picker #(.N(NUM_REQ), .IW(OW)) u_picker (
    .i_eligible (w_eligible),
    .i_last     (r_last),
    .o_pick     (w_pick),
    .o_valid    (w_pick_valid)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (w_pick[k]) w_pick_idx = OW'(k);
  end

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_finish     = 1'b0;
    w_cancel     = 1'b0;
    w_bypass     = 1'b0;
    unique case (r_state)
      DivArbIdle: begin
        if (w_pick_valid) begin
`ifdef DIV_ARB_ZERO_BYPASS_EN
          if (w_op2[w_pick_idx] == 32'd0) begin
            w_bypass = 1'b1;
          end else begin
            w_grant      = 1'b1;
            w_next_state = DivArbBusy;
          end
`else
          w_grant      = 1'b1;
          w_next_state = DivArbBusy;
`endif
        end
      end
      DivArbBusy: begin
        // Cancel wins over a same-cycle ready: the result is discarded.
        if (cancel_i[r_owner]) begin
          w_cancel     = 1'b1;
          w_next_state = DivArbCancel;
        end else if (div_ready_i == DivResultReady) begin
          w_finish     = 1'b1;
          w_next_state = DivArbStop;
        end
      end
      DivArbStop:   w_next_state = DivArbIdle;
      DivArbCancel: if (r_cnt == 2'(CancelCycles - 1)) w_next_state = DivArbIdle;
      default:      w_next_state = DivArbIdle;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order within the block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the latched operands and result are reset too, because they
      // drive outputs that must read zero straight out of reset.
      r_state  <= DivArbIdle;
      r_owner  <= '0;
      r_last   <= OW'(NUM_REQ - 1);
      r_signed <= 1'b0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_result <= '0;
      r_done   <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next_state;
      r_done  <= '0;
      r_cnt   <= (r_state == DivArbCancel) ? r_cnt + 2'd1 : 2'd0;
      if (w_grant) begin
        r_owner  <= w_pick_idx;
        r_signed <= signed_i[w_pick_idx];
        r_op1    <= w_op1[w_pick_idx];
        r_op2    <= w_op2[w_pick_idx];
      end
      if (w_finish) begin
        r_result         <= div_result_i;
        r_done[r_owner]  <= 1'b1;
        r_last           <= r_owner;
      end
      if (w_cancel) r_last <= r_owner;
      if (w_bypass) begin
        r_result           <= '0;
        r_done[w_pick_idx] <= 1'b1;
        r_last             <= w_pick_idx;
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    if (r_state != DivArbIdle) w_gnt[r_owner] = 1'b1;
  end

  assign gnt_o         = w_gnt;
  assign done_o        = r_done;
  assign result_o      = r_result;
  assign busy_o        = (r_state != DivArbIdle);
  assign div_start_o   = (r_state == DivArbBusy) ? DivStart : DivStop;
  assign div_annul_o   = (r_state == DivArbCancel);
  assign div_signed_o  = r_signed;
  assign div_opdata1_o = r_op1;
  assign div_opdata2_o = r_op2;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed bench for div_arbiter with a cycle-timed divider model
// (on at E1, ready at E35, or E3 for a zero divisor; held until start drops or annul).
module tb_div_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_i = '0, cancel_i = '0, signed_i = '0;
  logic [63:0] opdata1_i = '0, opdata2_i = '0;
  logic [1:0]  gnt_o, done_o;
  logic [63:0] result_o;
  logic        busy_o, div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_opdata1_o, div_opdata2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;

  div_arbiter #(.NUM_REQ(2)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .cancel_i(cancel_i), .signed_i(signed_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .gnt_o(gnt_o), .done_o(done_o),
    .result_o(result_o), .busy_o(busy_o), .div_start_o(div_start_o),
    .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
    .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] div_ref(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  logic       m_run, m_end;
  logic [5:0] m_rem;
  always @(posedge clk) begin
    if (!rst) begin
      m_run <= 1'b0; m_end <= 1'b0; m_rem <= '0;
      div_ready_i <= 1'b0; div_result_i <= '0;
    end else if (div_annul_o) begin
      m_run <= 1'b0; m_end <= 1'b0; div_ready_i <= 1'b0;
    end else if (m_end) begin
      if (!div_start_o) begin m_end <= 1'b0; div_ready_i <= 1'b0; end
    end else if (m_run) begin
      if (m_rem == 6'd1) begin
        m_run <= 1'b0; m_end <= 1'b1; div_ready_i <= 1'b1;
        div_result_i <= div_ref(div_signed_o, div_opdata1_o, div_opdata2_o);
      end else m_rem <= m_rem - 6'd1;
    end else if (div_start_o) begin
      m_run <= 1'b1;
      m_rem <= (div_opdata2_o == 32'd0) ? 6'd2 : 6'd34;
    end
  end

  int checks = 0, failures = 0, cyc = 0;

  task automatic step();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [1:0] v);
    case (v)
      2'b01:   return 0;
      2'b10:   return 1;
      default: return -1;
    endcase
  endfunction

  task automatic wait_gnt(output int idx, output int at);
    logic [1:0] prev = gnt_o;
    idx = -1; at = cyc;
    for (int i = 0; i < 200; i++) begin
      step();
      if (gnt_o != 2'b00 && prev == 2'b00) begin idx = oh_idx(gnt_o); at = cyc; return; end
      prev = gnt_o;
    end
    checks++; failures++;
    $display("FAIL wait_gnt: actual=no grant in 200 cycles required=grant");
  endtask

  task automatic wait_done(output int idx, output int at);
    idx = -1; at = cyc;
    for (int i = 0; i < 200; i++) begin
      if (done_o != 2'b00) begin idx = oh_idx(done_o); at = cyc; return; end
      step();
    end
    checks++; failures++;
    $display("FAIL wait_done: actual=no done in 200 cycles required=done pulse");
  endtask

  task automatic do_reset();
    rst = 1'b0; req_i = '0; cancel_i = '0; signed_i = '0;
    step(); step();
    rst = 1'b1;
  endtask

  typedef struct {
    int          req;
    logic        sgn;
    logic [31:0] op1, op2;
    logic [63:0] exp_res;
    int          exp_lat;
  } vec_t;
  vec_t vecs[$];

  localparam logic [63:0] R_100_7  = {32'd2, 32'd14};
  localparam logic [63:0] R_M7_2   = {32'hFFFFFFFF, 32'hFFFFFFFD};
  localparam logic [63:0] R_LAST   = {32'd15, 32'h0FFFFFFF};

  initial begin
    int gi, gat, di, dat, prev_at;
    logic [63:0] exp_b [2];

    `ifndef DIV_ARB_ZERO_BYPASS_EN
    vecs.push_back('{0, 1'b0, 32'd5, 32'd0, 64'd0, 4});
    `endif
    vecs.push_back('{0, 1'b0, 32'd100, 32'd7, R_100_7, 36});
    vecs.push_back('{1, 1'b1, 32'hFFFFFFF9, 32'd2, R_M7_2, 36});
    vecs.push_back('{0, 1'b1, 32'd100, 32'hFFFFFFF9, {32'd2, 32'hFFFFFFF2}, 36});
    vecs.push_back('{1, 1'b0, 32'hFFFFFFFF, 32'd16, R_LAST, 36});

    // Reset state
    do_reset();
    check("reset_ctl", {56'd0, gnt_o, done_o, busy_o, div_start_o, div_annul_o, div_signed_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_ops", {div_opdata1_o, div_opdata2_o}, 64'd0);

    // Two requesters together: 0 wins first, then grants alternate back-to-back
    exp_b[0] = R_100_7; exp_b[1] = R_M7_2;
    signed_i = 2'b10;
    opdata1_i = {32'hFFFFFFF9, 32'd100};
    opdata2_i = {32'd2, 32'd7};
    req_i = 2'b11;
    prev_at = 0;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(gi, gat);
      check($sformatf("rr_gnt%0d", i), gi, i % 2);
      if (i > 0) check($sformatf("rr_gap%0d", i), gat - prev_at, 38);
      prev_at = gat;
      wait_done(di, dat);
      check($sformatf("rr_done%0d", i), di, i % 2);
      check($sformatf("rr_lat%0d", i), dat - gat, 36);
      check($sformatf("rr_res%0d", i), result_o, exp_b[i % 2]);
    end
    req_i = '0;
    step(); step();

    // Single-requester vectors; operand inputs are scrambled after grant
    for (int v = 0; v < vecs.size(); v++) begin
      req_i = '0; req_i[vecs[v].req] = 1'b1;
      signed_i = '0; signed_i[vecs[v].req] = vecs[v].sgn;
      opdata1_i[32*vecs[v].req +: 32] = vecs[v].op1;
      opdata2_i[32*vecs[v].req +: 32] = vecs[v].op2;
      wait_gnt(gi, gat);
      check($sformatf("vec%0d_gnt", v), gi, vecs[v].req);
      check($sformatf("vec%0d_op2", v), div_opdata2_o, vecs[v].op2);
      opdata1_i = 64'h1234_5678_9ABC_DEF0;
      opdata2_i = 64'h0FED_CBA9_8765_4321;
      signed_i = ~signed_i;
      wait_done(di, dat);
      check($sformatf("vec%0d_done", v), di, vecs[v].req);
      check($sformatf("vec%0d_lat", v), dat - gat, vecs[v].exp_lat);
      check($sformatf("vec%0d_res", v), result_o, vecs[v].exp_res);
      check($sformatf("vec%0d_op1", v), div_opdata1_o, vecs[v].op1);
      req_i = '0;
      step(); step();
    end

    // Cancel coincident with divider ready: result discarded, annul sequence taken
    signed_i = '0;
    opdata1_i = {32'd0, 32'd100}; opdata2_i = {32'd0, 32'd7};
    req_i = 2'b01;
    wait_gnt(gi, gat);
    repeat (35) step();
    check("coin_ready_seen", {63'd0, div_ready_i}, 64'd1);
    cancel_i = 2'b01;
    step();
    check("coin_c0", {61'd0, div_annul_o, div_start_o, |done_o}, 64'b100);
    check("coin_res0", result_o, R_LAST);
    cancel_i = '0; req_i = '0;
    step();
    check("coin_c1", {61'd0, div_annul_o, div_start_o, |done_o}, 64'b100);
    step();
    check("coin_idle", {61'd0, busy_o, div_annul_o, |done_o}, 64'd0);
    check("coin_res1", result_o, R_LAST);

    // Owner cancels at grant+10; requester 1 is served next
    do_reset();
    opdata1_i = {32'd9, 32'd100}; opdata2_i = {32'd3, 32'd7};
    req_i = 2'b11;
    wait_gnt(gi, gat);
    check("can_gnt0", gi, 0);
    repeat (10) step();
    cancel_i = 2'b01;
    step();
    prev_at = cyc;
    check("can_c0", {60'd0, gnt_o, div_annul_o, div_start_o}, 64'b0110);
    cancel_i = '0; req_i[0] = 1'b0;
    step();
    check("can_c1", {61'd0, div_annul_o, div_start_o, |done_o}, 64'b100);
    step();
    check("can_idle", {61'd0, busy_o, div_annul_o, |done_o}, 64'd0);
    wait_gnt(gi, gat);
    check("can_gnt1", gi, 1);
    check("can_gap", gat - prev_at, 3);
    wait_done(di, dat);
    check("can_done1", di, 1);
    check("can_res1", result_o, {32'd0, 32'd3});
    req_i = '0;
    step(); step();

    `ifdef DIV_ARB_ZERO_BYPASS_EN
    // Zero divisor answered in IDLE without starting the divider
    opdata1_i = {32'd0, 32'd5}; opdata2_i = '0;
    req_i = 2'b01;
    step();
    check("byp_done", {62'd0, done_o}, 64'b01);
    check("byp_res", result_o, 64'd0);
    check("byp_gnt", {62'd0, gnt_o}, 64'd0);
    req_i = '0;
    begin
      logic seen = div_start_o | busy_o;
      for (int i = 0; i < 4; i++) begin step(); seen |= div_start_o | busy_o; end
      check("byp_nostart", {63'd0, seen}, 64'd0);
    end
    `endif

    // Reset during BUSY at grant+20; requester 0 wins first afterwards
    opdata1_i = {32'd100, 32'd100}; opdata2_i = {32'd7, 32'd7};
    req_i = 2'b10;
    wait_gnt(gi, gat);
    repeat (20) step();
    rst = 1'b0;
    step();
    check("rst_ctl", {56'd0, gnt_o, done_o, busy_o, div_start_o, div_annul_o, div_signed_o}, 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_ops", {div_opdata1_o, div_opdata2_o}, 64'd0);
    rst = 1'b1;
    req_i = 2'b11;
    wait_gnt(gi, gat);
    check("rst_gnt0", gi, 0);
    wait_done(di, dat);
    check("rst_res", result_o, R_100_7);
    req_i = '0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Shares the single multi-cycle divider between up to four requesters, such as the EX stage and a coprocessor or debug port. It sits between the requesters and the divider. It selects a requester round-robin, latches that requester's operands, and sequences the divider's start/stop/annul handshake. It returns the 64-bit result to the owner with a one-cycle done pulse.

## Interface
- NUM_REQ, 2, number of requesters (legal 2..4)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- req_i  in  NUM_REQ  per-requester request; level, held until own done_o or cancel
- cancel_i  in  NUM_REQ  per-requester flush; cancels own pending/active divide
- signed_i  in  NUM_REQ  per-requester signed-divide flag
- opdata1_i  in  32*NUM_REQ  dividends, requester k at [32k+31:32k]
- opdata2_i  in  32*NUM_REQ  divisors, same packing
- gnt_o  out  NUM_REQ  one-hot owner, high in BUSY/STOP/CANCEL
- done_o  out  NUM_REQ  one-cycle completion pulse to owner
- result_o  out  64  {remainder, quotient}; held until next done
- busy_o  out  1  state != IDLE
- div_start_o  out  1  to divider start (DivStart=1/DivStop=0)
- div_annul_o  out  1  to divider annul
- div_signed_o  out  1  latched signed flag
- div_opdata1_o / div_opdata2_o  out  32  latched operands
- div_result_i  in  64  divider result
- div_ready_i  in  1  divider result ready

## Operation
- States: IDLE, BUSY, STOP, CANCEL.
- IDLE: eligible requesters are req_i & ~cancel_i. Among them, pick by round-robin starting at last_owner+1.
  - On a pick: latch owner, signed, op1 and op2 into registers; go to BUSY.
  - No pick: stay in IDLE.
- BUSY: div_start_o=1 and div_annul_o=0. Latched operands are held stable for the whole divide, because the divider re-reads the sign bits at its final step.
  - Owner cancel_i=1: go to CANCEL. Cancel has priority over a same-cycle div_ready_i.
  - Otherwise, div_ready_i=1: register result_o, pulse done_o[owner], update last_owner, go to STOP.
- STOP: div_start_o=0 for exactly one cycle, so the divider returns to free; then go to IDLE.
- CANCEL: div_start_o=0, div_annul_o=1 for exactly 2 cycles (2-bit counter).
  - This covers a divider in its divide-by-zero or end state as well as mid-iteration.
  - Then go to IDLE. No done_o pulse; result_o is unchanged; last_owner is updated.
- cancel_i for a non-owner: masks that requester in IDLE only.
- div_annul_o is 0 outside CANCEL. div_start_o is 0 outside BUSY.
- Non-owner requests simply wait; no starvation: each requester waits at most NUM_REQ-1 divides.
- Reset values: state IDLE, last_owner=NUM_REQ-1 (so requester 0 wins first), all outputs 0, result_o 0.
- Reset mid-operation: the arbiter returns to IDLE immediately. The divider shares the reset.

## Timing
- E0 is the grant edge (IDLE→BUSY).
- Nonzero divisor:
  - Divider reaches its on state at E1, iterates E2..E33, ends at E34, asserts ready at E35.
  - Arbiter samples ready at E36. done_o and result_o are valid in the cycle after E36 (36 cycles).
- Zero divisor: ready at E3; done_o after E4; result 0.
- STOP→IDLE at E37; next grant at E38 at the earliest. A back-to-back divide therefore takes 38 cycles.
- Cancel: state is IDLE two cycles after the CANCEL entry edge; the next grant follows one edge later.

## Configuration
- DIV_ARB_ZERO_BYPASS_EN
  - Defined: in IDLE, a picked request with a zero divisor does not start the divider. At the grant edge the block sets result_o=0 and pulses done_o (valid after E0), updates last_owner and stays in IDLE; gnt_o is not asserted.
  - Undefined: zero divisors go through the divider as a normal divide, with done after E4.

## Structure
- State encodings (DivArbIdle, DivArbBusy, DivArbStop, DivArbCancel) go in the shared defines.v, next to the existing DivStart/DivStop/DivResultReady constants.
- One sub-module, rr_picker: combinational round-robin, inputs eligible vector and last_owner, outputs one-hot pick and valid. It is reusable by other shared-resource arbiters.

## Test plan
- Requester 0 divides 100/7 unsigned → done_o[0] 36 cycles after grant, result_o = {32'd2, 32'd14}.
- Requesters 0 and 1 request together, 1 signed −7/2 → 0 served first; then 1 gets result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}; grants alternate on repeat.
- Owner asserts cancel_i at grant+10 → 2 cycles with div_annul_o=1, div_start_o=0; no done_o; next requester granted after; its result is correct.
- Divisor 0 without the macro → done_o after E4, result_o=0. With DIV_ARB_ZERO_BYPASS_EN → done_o in the cycle after grant, div_start_o never rises.
- rst low during BUSY at grant+20 → next cycle all outputs 0, state IDLE; a subsequent request is granted to requester 0 first.
- cancel_i coincident with div_ready_i in BUSY → no done_o, result_o unchanged, CANCEL sequence taken.
